// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between the instruction-fetch requester
// (i_*) and the load/store requester (d_*). Each access goes through a
// registered request/acknowledge handshake on both sides. A streak counter
// forces a fetch grant after MAX_DSTREAK consecutive data grants made while
// a fetch was waiting. A per-access timeout aborts an access the memory
// never acknowledges.
//
// Ports
//   clk, reset             system clock, async active-high reset
//   i_req/i_addr           fetch request and word address
//   i_ack/i_rdata          one-cycle fetch completion and fetched word
//   d_req/d_we/d_addr/d_wdata  data request, store flag, address, store data
//   d_ack/d_rdata          one-cycle data completion and load data
//   err                    pulses with i_ack/d_ack when the access timed out
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request
//   mem_ack/mem_rdata      memory completion and read data
//   stall                  high while either requester is waiting
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | sampling i_req/d_req, granting one of them
// BUSY_I  | fetch access outstanding, waiting for mem_ack or timeout
// BUSY_D  | data access outstanding, waiting for mem_ack or timeout
// ACK     | armed ack (and err) visible for this one cycle

module mem_port_arbiter #(
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [DATA_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int SW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] DSTREAK_MAX = SW'(MAX_DSTREAK);
  // Counter value during the last BUSY cycle before the abort (count starts at 0)
  localparam logic [TW-1:0] TCNT_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  state_t         state;
  logic [SW-1:0]  dstreak;
  logic [TW-1:0]  tcnt;
  logic           grant_d;
  logic           timeout_hit;

  // Data wins ties unless the fetch side has already been passed over too often
  assign grant_d     = d_req & ~(i_req & (dstreak == DSTREAK_MAX));
  assign timeout_hit = (TIMEOUT != 0) && (tcnt == TCNT_LAST);
  assign stall       = (i_req & ~i_ack) | (d_req & ~d_ack);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      dstreak   <= '0;
      tcnt      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      err       <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_req | d_req) begin
            mem_req <= 1'b1;
            tcnt    <= '0;
            if (grant_d) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              state     <= ST_BUSY_D;
              if (i_req && (dstreak != DSTREAK_MAX)) dstreak <= dstreak + 1'b1;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= i_addr;
              mem_wdata <= '0;
              state     <= ST_BUSY_I;
              dstreak   <= '0;
            end
          end
        end

        ST_BUSY_I, ST_BUSY_D: begin
          tcnt <= tcnt + 1'b1;
          // A completing ack in the timeout cycle takes priority over the abort
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= ST_ACK;
            if (state == ST_BUSY_I) begin
              i_ack   <= 1'b1;
              i_rdata <= mem_rdata;
            end else begin
              d_ack   <= 1'b1;
              d_rdata <= mem_rdata;
            end
          end else if (timeout_hit) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            state   <= ST_ACK;
            if (state == ST_BUSY_I) begin
              i_ack   <= 1'b1;
              i_rdata <= '0;
            end else begin
              d_ack   <= 1'b1;
              d_rdata <= '0;
            end
          end
        end

        ST_ACK: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          err   <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter. The reference model
// works per access: it picks the winner from the arbitration rules, derives
// the completion cycle from the memory latency and timeout, and tracks the
// last data returned to each requester.

module tb_mem_port_arbiter;

  localparam int DW   = 32;
  localparam int MAXD = 2;
  localparam int TO   = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_we, mem_ack;
  logic [DW-1:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic          i_ack, d_ack, err, mem_req, mem_we, stall;
  logic [DW-1:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int            m_streak;
  logic [DW-1:0] m_irdata, m_drdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(DW), .MAX_DSTREAK(MAXD), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall)
  );

  task automatic check_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic new_i();
    i_req  = 1'b1;
    i_addr = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic new_d();
    d_req   = 1'b1;
    d_we    = 1'($urandom);
    d_addr  = $urandom;
    d_wdata = $urandom;
  endtask

  // Entered at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
  // mode 0: random requests, 1: both requesters always busy, 2: no new requests, winner drops
  task automatic run_round(input int lat_sel, input int mode);
    int            n, fin, pick;
    bit            win_d, loser_req;
    logic [DW-1:0] rd, exp_addr, exp_wdata, exp_rd;
    logic          exp_we, timed_out;
    int            lats[8] = '{1, 2, 3, 4, 5, 15, 16, 20};

    if (mode == 1) begin
      if (!i_req) new_i();
      if (!d_req) new_d();
    end else if (mode == 0) begin
      if (!i_req && ($urandom % 2 == 0)) new_i();
      if (!d_req && ($urandom % 2 == 0)) new_d();
    end
    mem_ack   = ($urandom % 4 == 0);   // stray ack in IDLE must be ignored
    mem_rdata = $urandom;
    @(negedge clk);
    check_val("idle_i_ack", i_ack, 0);
    check_val("idle_d_ack", d_ack, 0);
    check_val("idle_err", err, 0);
    check_val("idle_mem_req", mem_req, 0);
    check_val("idle_stall", stall, i_req | d_req);
    check_val("hold_i_rdata", i_rdata, m_irdata);
    check_val("hold_d_rdata", d_rdata, m_drdata);
    if (!i_req && !d_req) begin
      next_cycle();
      return;
    end

    win_d = d_req && !(i_req && m_streak == MAXD);
    if (win_d && i_req) m_streak = (m_streak + 1 > MAXD) ? MAXD : m_streak + 1;
    else if (!win_d)    m_streak = 0;
    exp_we    = win_d ? d_we : 1'b0;
    exp_addr  = win_d ? d_addr : i_addr;
    exp_wdata = win_d ? d_wdata : '0;

    if (lat_sel > 0) n = lat_sel;
    else begin
      pick = int'($urandom % 8);
      n = lats[pick];
    end
    timed_out = (n > TO);
    fin = timed_out ? TO : n;
    rd = '0;

    for (int c = 1; c <= fin + 1; c++) begin
      next_cycle();
      mem_ack   = (c == n);
      mem_rdata = $urandom;
      if (c == n) rd = mem_rdata;
      @(negedge clk);
      if (c <= fin) begin
        check_val("busy_mem_req", mem_req, 1);
        check_val("busy_mem_we", mem_we, exp_we);
        check_val("busy_mem_addr", mem_addr, exp_addr);
        check_val("busy_mem_wdata", mem_wdata, exp_wdata);
        check_val("busy_acks", {i_ack, d_ack, err}, 0);
        check_val("busy_stall", stall, 1);
      end else begin
        exp_rd = timed_out ? '0 : rd;
        if (win_d) m_drdata = exp_rd;
        else       m_irdata = exp_rd;
        loser_req = win_d ? i_req : d_req;
        check_val("ack_i_ack", i_ack, !win_d);
        check_val("ack_d_ack", d_ack, win_d);
        check_val("ack_err", err, timed_out);
        check_val("ack_i_rdata", i_rdata, m_irdata);
        check_val("ack_d_rdata", d_rdata, m_drdata);
        check_val("ack_mem_req", mem_req, 0);
        check_val("ack_stall", stall, loser_req);
      end
    end

    next_cycle();
    if (mode == 2 || (mode == 0 && $urandom % 2 == 0)) begin
      if (win_d) d_req = 1'b0;
      else       i_req = 1'b0;
    end else begin
      if (win_d) new_d();
      else       new_i();
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 4 && (i_req || d_req); k++) run_round(1, 2);
    check_val("drained", {i_req, d_req}, 0);
  endtask

  initial begin
    reset = 1'b1;
    i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    m_streak = 0; m_irdata = '0; m_drdata = '0;
    repeat (2) @(negedge clk);
    check_val("rst_mem_req", mem_req, 0);
    check_val("rst_mem_we", mem_we, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_mem_wdata", mem_wdata, 0);
    check_val("rst_acks", {i_ack, d_ack, err}, 0);
    check_val("rst_i_rdata", i_rdata, 0);
    check_val("rst_d_rdata", d_rdata, 0);
    next_cycle();
    reset = 1'b0;

    // single load, 1-cycle memory
    d_req = 1; d_we = 0; d_addr = 32'h40; d_wdata = '0;
    run_round(1, 2);
    // store acked in cycle 4
    d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h1234_5678;
    run_round(4, 2);
    // fetch timeout, then ack in the timeout cycle, then a normal fetch
    new_i(); run_round(20, 2);
    new_i(); run_round(TO, 2);
    new_i(); run_round(1, 2);

    // both held continuously: D, D, I, D, D, I
    for (int k = 0; k < 6; k++) run_round(1, 1);
    drain();

    for (int k = 0; k < 300; k++) run_round(0, 0);
    drain();

    // reset in the second cycle of a data access
    new_d();
    mem_ack = 0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check_val("pre_rst_mem_req", mem_req, 1);
    next_cycle();
    reset = 1'b1;
    new_i();
    #1;
    check_val("midrst_mem_req", mem_req, 0);
    check_val("midrst_d_ack", d_ack, 0);
    check_val("midrst_err", err, 0);
    d_req = 1'b0;
    m_streak = 0; m_irdata = '0; m_drdata = '0;
    @(negedge clk);
    next_cycle();
    reset = 1'b0;
    run_round(1, 2);

    for (int k = 0; k < 50; k++) run_round(0, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
